// File: rtl/bus_grant7_pkg.sv
// Shared definitions for the bus_grant7 arbiter: FSM encoding, hold-limit default, counter width.
// Also hosts the rotate-index helper used by the request picker.
package bus_grant7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int LIMIT_DEF = 16;
  localparam int CNT_W     = 8;

  // Requester visited at search position step (1..7) when searching just after start.
  function automatic logic [2:0] rot_idx(input logic [2:0] start, input int step);
    return 3'(((int'(start) + step - 1) % 7) + 1);
  endfunction

endpackage

// File: rtl/bus_grant7_if.sv
// Request/grant bundle between seven bus requesters (master) and the arbiter (slave).
// Grant-side signals are registered in the arbiter; requests and done are sampled on c.
interface bus_grant7_if;
  logic [7:1] a;
  logic       done;
  logic [7:1] g;
  logic [2:0] n;
  logic       busy;
  logic       to;

  modport master (output a, done, input g, n, busy, to);
  modport slave  (input a, done, output g, n, busy, to);
endinterface

// File: rtl/bus_grant7_pick7.sv
// Combinational picker: first set bit of mask searching start+1..7 then 1..start; zero latency.
// No backpressure; an empty mask yields pick=0, num=0.
module pick7
  import bus_grant7_pkg::*;
(
  input  logic [7:1] mask,
  input  logic [2:0] start,
  output logic [7:1] pick,
  output logic [2:0] num
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    pick  = '0;
    num   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 7; i++) begin
      idx = rot_idx(start, i);
      if (!found && mask[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        num       = idx;
      end
    end
  end

endmodule

// File: rtl/bus_grant7.sv
// 7-way bus arbiter IDLE/GRANT/GAP, grant one cycle after request, hold capped at LIMIT cycles.
// No backpressure: owner keeps the bus until done, request drop or timeout; ROUND_ROBIN_EN selects rotating priority.
module bus_grant7
  import bus_grant7_pkg::*;
#(
  parameter int LIMIT = LIMIT_DEF
) (
  input  logic         c,
  input  logic         r,
  bus_grant7_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [7:1]       g_q, g_nxt;
  logic [2:0]       n_q, n_nxt;
  logic             busy_q, busy_nxt;
  logic             to_q, to_nxt;
  logic [7:1]       pick;
  logic [2:0]       pick_num;
  logic [2:0]       rr_start;
  logic             owner_req;
  logic             hold_done;
  logic             grant_load;

  pick7 u_pick (
    .mask  (bus.a),
    .start (rr_start),
    .pick  (pick),
    .num   (pick_num)
  );

  assign grant_load = (state != GRANT) && (state_nxt == GRANT);

`ifdef ROUND_ROBIN_EN
  // Last granted requester; starting at 7 makes requester 1 first after reset.
  logic [2:0] ptr;

  always_ff @(posedge c) begin
    if (!r) begin
      ptr <= 3'd7;
    end else if (grant_load) begin
      ptr <= pick_num;
    end
  end

  assign rr_start = ptr;
`else
  assign rr_start = 3'd7;
`endif

  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign hold_done = (cnt_inc >= LIMIT_CNT);
  assign owner_req = |(bus.a & g_q);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    g_nxt     = g_q;
    n_nxt     = n_q;
    busy_nxt  = busy_q;
    to_nxt    = 1'b0;
    case (state)
      IDLE, GAP: begin
        cnt_nxt = '0;
        if (|bus.a) begin
          state_nxt = GRANT;
          g_nxt     = pick;
          n_nxt     = pick_num;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          g_nxt     = '0;
          n_nxt     = '0;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (bus.done || !owner_req || hold_done) begin
          state_nxt = GAP;
          g_nxt     = '0;
          n_nxt     = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          // Flag a timeout only when the owner would otherwise have kept the bus.
          to_nxt    = hold_done && !bus.done && owner_req;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        g_nxt     = '0;
        n_nxt     = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (!r) begin
      state  <= IDLE;
      cnt    <= '0;
      g_q    <= '0;
      n_q    <= '0;
      busy_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      g_q    <= g_nxt;
      n_q    <= n_nxt;
      busy_q <= busy_nxt;
      to_q   <= to_nxt;
    end
  end

  assign bus.g    = g_q;
  assign bus.n    = n_q;
  assign bus.busy = busy_q;
  assign bus.to   = to_q;

endmodule

// File: tb/tb_bus_grant7.sv
// Directed-vector bench for bus_grant7 (LIMIT=4): stimulus queues expected outputs, a monitor pops and compares.
// Also checks the one-hot / n-matches-g / turnaround invariants every cycle.
module tb_bus_grant7;

  logic c = 1'b0;
  logic r = 1'b0;

  bus_grant7_if bus ();

  bus_grant7 #(.LIMIT(4)) dut (
    .c   (c),
    .r   (r),
    .bus (bus)
  );

  always #5 c = ~c;

  logic [11:0] exp_q[$];
  string       nm_q[$];
  int          n_pass   = 0;
  int          n_checks = 0;
  bit          mon_on   = 1'b0;
  logic [7:1]  prev_g   = '0;

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic rv, input logic [7:1] av, input logic dv,
                      input logic [7:1] eg, input logic [2:0] en, input logic eb,
                      input logic et, input string nm);
    @(negedge c);
    r        = rv;
    bus.a    = av;
    bus.done = dv;
    exp_q.push_back({eg, en, eb, et});
    nm_q.push_back(nm);
  endtask

  always @(posedge c) begin
    logic [11:0] exp_v;
    logic [11:0] act;
    string       nm;
    logic [2:0]  gidx;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = nm_q.pop_front();
      act   = {bus.g, bus.n, bus.busy, bus.to};
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got g=%b n=%0d busy=%b to=%b, want g=%b n=%0d busy=%b to=%b",
                    nm, act[11:5], act[4:2], act[1], act[0],
                    exp_v[11:5], exp_v[4:2], exp_v[1], exp_v[0]);
      mon_on = 1'b1;
    end
    if (mon_on) begin
      gidx = '0;
      for (int i = 1; i <= 7; i++) if (bus.g[i]) gidx = 3'(i);
      n_checks++;
      if ($countones(bus.g) <= 1 && bus.n === gidx &&
          !(prev_g != '0 && bus.g != '0 && bus.g != prev_g))
        n_pass++;
      else $display("FAIL invariant: got g=%b n=%0d prev_g=%b, want onehot0 g, n=%0d, g=0 between owners",
                    bus.g, bus.n, prev_g, gidx);
      prev_g = bus.g;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, want finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0] en;
    logic [7:1] oh;
    bus.a    = '0;
    bus.done = 1'b0;

    step(1'b0, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "reset");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_no_req");

    // Priority, done release through GAP, requests ignored while granted
    step(1'b1, 7'b1010100, 1'b0, 7'b0000100, 3'd3, 1'b1, 1'b0, "prio_grant3");
    step(1'b1, 7'b1010000, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, "prio_done_gap");
    step(1'b1, 7'b1010000, 1'b0, 7'b0010000, 3'd5, 1'b1, 1'b0, "prio_grant5");
    step(1'b1, 7'b1010001, 1'b0, 7'b0010000, 3'd5, 1'b1, 1'b0, "grant_stable");
    step(1'b1, 7'b1000001, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, "done_gap5");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "gap_to_idle");

    // Owner drops its request
    step(1'b1, 7'b0100000, 1'b0, 7'b0100000, 3'd6, 1'b1, 1'b0, "grant6");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "drop6_gap_no_to");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_after_drop");

    // Timeout after exactly LIMIT=4 cycles, then re-grant
    step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "to_grant");
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "to_hold");
    step(1'b1, 7'b0000010, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b1, "to_pulse");
    step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "to_regrant");
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "limit_hold");
    step(1'b1, 7'b0000010, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, "limit_done_no_to");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_after_limit");

    // Request drop coinciding with the limit is not a timeout
    step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "drop_lim_grant");
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "drop_lim_hold");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "limit_drop_no_to");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_after_drop_lim");

    // done with a fresh request must still pass through GAP
    step(1'b1, 7'b0000001, 1'b0, 7'b0000001, 3'd1, 1'b1, 1'b0, "grant1");
    step(1'b1, 7'b0000011, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, "done_newreq_gap");
    step(1'b1, 7'b0000010, 1'b0, 7'b0000010, 3'd2, 1'b1, 1'b0, "after_gap_grant2");
    step(1'b1, 7'b0000000, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, "gap_b");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_b");

    // Reset in the middle of a grant
    step(1'b1, 7'b0000100, 1'b0, 7'b0000100, 3'd3, 1'b1, 1'b0, "pre_rst_grant");
    step(1'b0, 7'b0000100, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "rst_midgrant");
    step(1'b1, 7'b0000100, 1'b0, 7'b0000100, 3'd3, 1'b1, 1'b0, "post_rst_grant");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "gap_c");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_c");

    // All requesting, done each grant: rotates under round robin, stays on 1 otherwise
    step(1'b0, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "rst_rr");
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "idle_rr");
    for (int k = 0; k < 8; k++) begin
`ifdef ROUND_ROBIN_EN
      en = 3'((k % 7) + 1);
`else
      en = 3'd1;
`endif
      oh     = '0;
      oh[en] = 1'b1;
      step(1'b1, 7'b1111111, 1'b0, oh, en, 1'b1, 1'b0, "all_req_grant");
      step(1'b1, 7'b1111111, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, "all_req_gap");
    end
    step(1'b1, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, "drain_idle");

    repeat (3) @(posedge c);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_grant7.md
BUS_GRANT7 -- requirements
Module: bus_grant7

Interface
REQ-001 Parameter LIMIT, default 16, SHALL set the maximum consecutive cycles one requester holds the bus (legal 1..255).
REQ-002 c  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 r  input  1  reset; synchronous and active-low.
REQ-004 a  input  [7:1]  request lines; a[k] high means requester k wants the shared 8-bit bus.
REQ-005 done  input  1  current owner releases the bus; sampled only in GRANT.
REQ-006 g  output  [7:1]  one-hot grant; drives the bus-driver enables; at most one bit high, ever.
REQ-007 n  output  [2:0]  number of the granted requester; 0 when no grant.
REQ-008 busy  output  1  high while in GRANT.
REQ-009 to  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 States SHALL be IDLE, GRANT and GAP; g, n and busy SHALL be registered outputs.
REQ-011 IDLE: any a high -> GRANT next edge, with g one-hot of the selected requester and n its number; no request -> stay IDLE.
REQ-012 Grant latency SHALL be exactly one cycle from the first sampled request in IDLE.
REQ-013 Fixed-priority selection: the lowest-numbered asserted request wins.
REQ-014 GRANT: done high, or a[n] low, or hold count reaching LIMIT -> GAP next edge, with g=0, n=0 and busy=0.
REQ-015 The hold counter SHALL clear on entry to GRANT and increment each GRANT cycle; g SHALL be high for at most LIMIT cycles.
REQ-016 to SHALL pulse in the GAP cycle only when the timeout alone caused the release; done or a[n] low with the count at LIMIT SHALL NOT pulse to.
REQ-017 GAP SHALL last exactly one cycle with g=0 (bus turnaround); it SHALL then arbitrate like IDLE, going to GRANT on any request or to IDLE otherwise.
REQ-018 Requests changing during GRANT SHALL NOT alter g or n until release.
REQ-019 Simultaneous done and new requests SHALL still pass through GAP; two grants SHALL never be adjacent.
REQ-020 The counter SHALL saturate and never wrap.

Reset
REQ-021 r low at a rising edge SHALL force IDLE, g=0, n=0, busy=0, to=0 and counter=0, overriding all other inputs including mid-grant.
REQ-022 The first grant after reset release SHALL need a request sampled in IDLE, giving one-cycle latency.

Configuration
REQ-023 Macro ROUND_ROBIN_EN defined: after a grant to requester k, the next selection SHALL search k+1..7 then 1..k; the pointer SHALL reset to 7, so requester 1 is highest first.
REQ-024 ROUND_ROBIN_EN undefined: selection SHALL be fixed priority per REQ-013, with no pointer state.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE, GRANT, GAP), the LIMIT default and the counter width (8).
REQ-026 One combinational sub-module, pick7, SHALL map a 7-bit request mask and a rotate start to a one-hot pick and a number; the rotate input is tied off without ROUND_ROBIN_EN.

Verification
REQ-027 Reset mid-grant: g=0000100, r low one edge -> g=0, n=0, busy=0 at that edge; requests held -> new grant one cycle after r high.
REQ-028 Priority: a=1010100 in IDLE -> next cycle g=0000100, n=3; done pulse -> one GAP cycle with g=0, then g=0010000, n=5.
REQ-029 Timeout: LIMIT=4, a[2] held, done low -> g[2] high exactly 4 cycles, GAP with to=1, then re-grant n=2 (fixed) or the next requester (round robin).
REQ-030 Owner drop: in GRANT with n=6, a[6] falls -> GAP next edge, to=0.
REQ-031 Round robin (ROUND_ROBIN_EN): a=1111111, done pulsed each grant -> n sequence 1,2,3,4,5,6,7,1.
REQ-032 Invariant checks every cycle: popcount(g) <= 1; n equals the index of g; at least one g=0 cycle between different owners.
